// File: rtl/inv_response_checker.sv
// Response checker for the single-bit inverter datapath. Delays each accepted
// stimulus bit by the DUT latency, compares the DUT response against its
// inverse, and reports pass/fail after a programmed number of compares.
module inv_response_checker #(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned NUM_CHECKS = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stim_valid,
  input  logic             stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] NUM      = CNT_W'(NUM_CHECKS);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_err_q, first_err_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic             pass_q, pass_d;

  logic restart;
  logic issue;
  logic cmp_valid;
  logic cmp_bit;
  logic do_cmp;
  logic mismatch;

  // start is only honoured outside RUN; it also flushes the delay line
  assign restart  = start && (state_q != ST_RUN);
  assign issue    = (state_q == ST_RUN) && stim_valid && (issue_cnt_q < NUM);
  assign do_cmp   = (state_q == ST_RUN) && cmp_valid;
  assign mismatch = do_cmp && (resp != ~cmp_bit);

  generate
    if (LATENCY == 0) begin : g_no_delay
      // Zero latency: compare against the stimulus accepted this very cycle
      assign cmp_valid = issue;
      assign cmp_bit   = stim;
    end else begin : g_delay
      logic [LATENCY-1:0] dl_valid_q;
      logic [LATENCY-1:0] dl_bit_q;

      // Free-running shift of {valid, bit}; non-issue cycles become bubbles
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dl_valid_q <= '0;
          dl_bit_q   <= '0;
        end else if (restart) begin
          dl_valid_q <= '0;
          dl_bit_q   <= '0;
        end else begin
          dl_valid_q[0] <= issue;
          dl_bit_q[0]   <= stim;
          for (int i = 1; i < LATENCY; i++) begin
            dl_valid_q[i] <= dl_valid_q[i-1];
            dl_bit_q[i]   <= dl_bit_q[i-1];
          end
        end
      end

      assign cmp_valid = dl_valid_q[LATENCY-1];
      assign cmp_bit   = dl_bit_q[LATENCY-1];
    end
  endgenerate

  // Next-state for the FSM, counters and verdict
  always_comb begin
    state_d     = state_q;
    chk_cnt_d   = chk_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    issue_cnt_d = issue_cnt_q;
    pass_d      = pass_q;

    if (restart) begin
      state_d     = ST_RUN;
      chk_cnt_d   = '0;
      err_cnt_d   = '0;
      first_err_d = ALL_ONES;
      issue_cnt_d = '0;
      pass_d      = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (issue) begin
        issue_cnt_d = issue_cnt_q + 1'b1;
      end
      if (do_cmp) begin
        chk_cnt_d = chk_cnt_q + 1'b1;
        if (mismatch) begin
          if (err_cnt_q != ALL_ONES) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          // err_cnt saturates but never returns to zero, so zero means "no error yet"
          if (err_cnt_q == '0) begin
            first_err_d = chk_cnt_q;
          end
        end
        if (chk_cnt_d == NUM) begin
          state_d = ST_DONE;
          pass_d  = (err_cnt_d == '0);
        end
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= ALL_ONES;
      issue_cnt_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chk_cnt_q   <= chk_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      issue_cnt_q <= issue_cnt_d;
      pass_q      <= pass_d;
    end
  end

  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign pass          = pass_q;
  assign chk_cnt       = chk_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_inv_response_checker.sv
// Bench for inv_response_checker: a LATENCY=1/NUM_CHECKS=4 instance and a
// LATENCY=0/NUM_CHECKS=2 instance, driven by directed steps with a result scoreboard.
module tb_inv_response_checker;

  typedef struct {
    logic       pass;
    logic [7:0] chk;
    logic [7:0] err;
    logic [7:0] fidx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  // LATENCY=1 instance
  logic start, stim_valid, stim, resp;
  logic busy, done, pass;
  logic [7:0] chk_cnt, err_cnt, first_err_idx;

  // LATENCY=0 instance
  logic start0, stim_valid0, stim0, resp0;
  logic busy0, done0, pass0;
  logic [7:0] chk_cnt0, err_cnt0, first_err_idx0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic pend;
  int   wticks;

  always #5 clk = ~clk;

  inv_response_checker #(.LATENCY(1), .NUM_CHECKS(4), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim_valid(stim_valid), .stim(stim),
    .resp(resp), .busy(busy), .done(done), .pass(pass), .chk_cnt(chk_cnt),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  inv_response_checker #(.LATENCY(0), .NUM_CHECKS(2), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stim_valid(stim_valid0), .stim(stim0),
    .resp(resp0), .busy(busy0), .done(done0), .pass(pass0), .chk_cnt(chk_cnt0),
    .err_cnt(err_cnt0), .first_err_idx(first_err_idx0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference model of one LATENCY=1 run; only the first 4 valid cycles are issued
  function automatic exp_t model(input int n, input logic [7:0] vmask, input logic [7:0] fmask);
    exp_t e;
    int   issued;
    e.err  = 8'd0;
    e.fidx = 8'hFF;
    issued = 0;
    for (int i = 0; i < n; i++) begin
      if (vmask[i] && issued < 4) begin
        if (fmask[i]) begin
          if (e.err == 8'd0) e.fidx = 8'(issued);
          e.err = e.err + 8'd1;
        end
        issued++;
      end
    end
    e.chk  = 8'(issued);
    e.pass = (e.err == 8'd0);
    return e;
  endfunction

  // Drives n cycles; the DUT response for a valid cycle appears one cycle later,
  // inverted unless the fault mask marks that cycle
  task automatic drive_run(input int n, input logic [7:0] vmask, input logic [7:0] bits,
                           input logic [7:0] fmask);
    for (int i = 0; i < n; i++) begin
      stim_valid = vmask[i];
      stim       = bits[i];
      resp       = pend;
      pend       = vmask[i] ? (~bits[i] ^ fmask[i]) : 1'b0;
      tick();
    end
    stim_valid = 1'b0;
  endtask

  task automatic wait_done(output int ticks);
    ticks = 0;
    while (!done && ticks < 20) begin
      stim_valid = 1'b0;
      resp       = pend;
      pend       = 1'b0;
      tick();
      ticks++;
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    check({tag, "_done"}, 32'(done), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'(e.pass));
      check({tag, "_chk"}, 32'(chk_cnt), 32'(e.chk));
      check({tag, "_err"}, 32'(err_cnt), 32'(e.err));
      check({tag, "_fidx"}, 32'(first_err_idx), 32'(e.fidx));
    end
  endtask

  initial begin
    exp_t e0;
    rst_n = 1'b0;
    {start, stim_valid, stim, resp} = '0;
    {start0, stim_valid0, stim0, resp0} = '0;
    pend = 1'b0;

    // Reset values
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_chk", 32'(chk_cnt), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_fidx", 32'(first_err_idx), 32'hFF);
    check("rst0_fidx", 32'(first_err_idx0), 32'hFF);
    #1 rst_n = 1'b1;
    tick();

    // Good DUT, stim 0,1,0,1
    pulse_start();
    check("run_busy", 32'(busy), 32'd1);
    sb.push_back(model(4, 8'h0F, 8'h00));
    drive_run(4, 8'h0F, 8'b0000_1010, 8'h00);
    check("good_not_done_early", 32'(done), 32'd0);
    wait_done(wticks);
    check("good_done_latency", 32'(wticks), 32'd1);
    check_result("good");

    // Buffer instead of inverter: every compare mismatches
    pulse_start();
    sb.push_back(model(4, 8'h0F, 8'h0F));
    drive_run(4, 8'h0F, 8'b0000_1010, 8'h0F);
    wait_done(wticks);
    check_result("buffer");

    // Bubbles, fault on 3rd compare, extra 5th stim_valid ignored
    pulse_start();
    sb.push_back(model(8, 8'b1101_0101, 8'b1001_0000));
    drive_run(8, 8'b1101_0101, 8'b0100_0001, 8'b1001_0000);
    wait_done(wticks);
    check_result("bubble");
    stim_valid = 1'b1;
    stim = 1'b1;
    resp = 1'b1;
    repeat (3) tick();
    stim_valid = 1'b0;
    check("done_hold_chk", 32'(chk_cnt), 32'd4);
    check("done_hold_err", 32'(err_cnt), 32'd1);
    check("done_hold_done", 32'(done), 32'd1);

    // LATENCY=0, same-cycle compare, start pulses while busy are ignored
    start0 = 1'b1;
    tick();
    e0 = '{pass: 1'b1, chk: 8'd2, err: 8'd0, fidx: 8'hFF};
    sb.push_back(e0);
    stim_valid0 = 1'b1; stim0 = 1'b1; resp0 = 1'b0;
    tick();
    check("lat0_mid_chk", 32'(chk_cnt0), 32'd1);
    stim0 = 1'b0; resp0 = 1'b1;
    tick();
    start0 = 1'b0;
    stim_valid0 = 1'b0;
    check("lat0_done", 32'(done0), 32'd1);
    if (sb.size() == 0) begin
      check("lat0_sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e0 = sb.pop_front();
      check("lat0_pass", 32'(pass0), 32'(e0.pass));
      check("lat0_chk", 32'(chk_cnt0), 32'(e0.chk));
      check("lat0_err", 32'(err_cnt0), 32'(e0.err));
      check("lat0_fidx", 32'(first_err_idx0), 32'(e0.fidx));
    end

    // Async reset mid-run after two compares
    pulse_start();
    drive_run(3, 8'h07, 8'b0000_0101, 8'h07);
    check("abort_chk_before", 32'(chk_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_chk", 32'(chk_cnt), 32'd0);
    check("abort_err", 32'(err_cnt), 32'd0);
    check("abort_fidx", 32'(first_err_idx), 32'hFF);
    #1 rst_n = 1'b1;
    pend = 1'b0;
    tick();
    pulse_start();
    sb.push_back(model(4, 8'h0F, 8'h00));
    drive_run(4, 8'h0F, 8'b0000_0110, 8'h00);
    wait_done(wticks);
    check_result("after_abort");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
